pixel_readout_capture: RTL and testbench
========================================

Name: pixel_readout_capture

Overview:
- Pixel-array-side counterpart of the exposure/readout controller. Consumes its Erase, Expose, NRE_1, NRE_2 and ADC control strobes and captures column ADC results for the 2x2 array.
- Reorders the captured data into a 4-word frame and streams it to downstream logic over a valid/ready handshake.
- Flags control sequences that violate the protocol.
- Sits between the column ADCs and the frame consumer.

Parameters:
- DATA_W, 8, width of each column ADC result and pixel word.

Ports:
- Clk  input  1  system clock; all activity on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Erase  input  1  erase strobe from controller, active high.
- Expose  input  1  exposure strobe from controller, active high.
- NRE_1  input  1  row 1 read enable, active low.
- NRE_2  input  1  row 2 read enable, active low.
- ADC  input  1  conversion strobe from controller, active high.
- ADC_data_c1  input  DATA_W  column 1 ADC result.
- ADC_data_c2  input  DATA_W  column 2 ADC result.
- Pix_valid  output  1  pixel word available.
- Pix_ready  input  1  consumer accepts word.
- Pix_data  output  DATA_W  pixel value.
- Pix_addr  output  2  pixel index: 0=r1c1, 1=r1c2, 2=r2c1, 3=r2c2.
- Frame_done  output  1  one-cycle pulse after the last word of a frame is accepted.
- Proto_err  output  1  sticky protocol-violation flag.
- Overrun  output  1  one-cycle pulse when a new exposure starts during drain.

Behaviour:
- All control inputs are synchronous to Clk. Edges are detected against one-cycle registered copies.
- Reset low (async): state=IDLE; edge registers=0; buffer=0; Pix_valid=0, Pix_data=0, Pix_addr=0, Frame_done=0, Proto_err=0, Overrun=0.
- "Capture edge" = cycle in which ADC_q=1 and ADC=0 (ADC falling edge). Data is sampled from ADC_data_c1/c2 in that cycle.
- Valid row selects: NRE_1=0,NRE_2=1 selects row 1. NRE_1=1,NRE_2=0 selects row 2. Both high or both low at a capture edge is a protocol error.
- States:
  - IDLE: Expose rising edge -> EXPOSE; Proto_err clears in the same cycle.
  - EXPOSE: Expose falling edge -> ROW1. Capture edge here sets Proto_err; state unchanged.
  - ROW1: capture edge with row 1 selected stores buf[0]=c1, buf[1]=c2 -> ROW2. Capture edge with any other select sets Proto_err -> IDLE.
  - ROW2: capture edge with row 2 selected stores buf[2]=c1, buf[3]=c2 -> DRAIN, rd_ptr=0. Other select sets Proto_err -> IDLE.
  - DRAIN:
    - Pix_valid=1 starting the cycle after entry. Pix_data=buf[rd_ptr], Pix_addr=rd_ptr.
    - On Pix_valid&&Pix_ready, rd_ptr increments.
    - Handshake at rd_ptr=3: Pix_valid drops next cycle, Frame_done=1 for one cycle, state -> IDLE.
    - Pix_data and Pix_addr stay stable while Pix_valid=1 and Pix_ready=0.
- Erase rising edge in EXPOSE, ROW1 or ROW2 aborts to IDLE. Partial buffer contents are discarded, no output, no error. Erase in IDLE or DRAIN is ignored.
- Expose rising edge in ROW1/ROW2 sets Proto_err and moves to EXPOSE (restart).
- Expose rising edge in DRAIN pulses Overrun for one cycle. The drain continues, and the new frame's strobes are ignored until IDLE is re-entered.
- Expose rising edge and Erase rising edge in the same cycle in IDLE: Expose wins -> EXPOSE.
- Minimum latency: ROW2 capture edge at cycle N gives Pix_valid at N+2. With Pix_ready held high, 4 words issue on N+2..N+5 and Frame_done pulses at N+6.
- Proto_err stays set until the next Expose rising edge taken from IDLE, or reset.

Test Plan:
- Nominal frame: Expose 1 for 3 cycles, then row 1 capture (c1=0x11, c2=0x22) and row 2 capture (c1=0x33, c2=0x44), Pix_ready=1 -> words (0,0x11),(1,0x22),(2,0x33),(3,0x44) on consecutive cycles, one Frame_done pulse, Proto_err=0.
- Backpressure: same frame with Pix_ready low for 5 cycles at each word -> each word held stable, no word lost or duplicated, Frame_done only after addr 3 is accepted.
- Protocol error: capture edge in ROW1 with NRE_1=NRE_2=0 -> Proto_err=1, return to IDLE, no Pix_valid. Next Expose rising edge clears Proto_err.
- Abort: Erase rising edge after row 1 capture -> IDLE. A following full frame (0xA0..0xA3) outputs only the new data.
- Overrun: Expose rising edge while in DRAIN with Pix_ready=0 -> Overrun pulse for exactly 1 cycle. The current frame drains intact, and the ignored exposure produces no words.
- Reset mid-DRAIN: assert Reset asynchronously between clock edges -> Pix_valid and all outputs 0 immediately. After release, state is IDLE.

Source files
------------

// File: rtl/pixel_readout_capture_if.sv
// Pixel output stream: one pixel word plus its array index per valid/ready handshake.
//   master : drives Pix_valid, Pix_data, Pix_addr; samples Pix_ready
//   slave  : samples Pix_valid, Pix_data, Pix_addr; drives Pix_ready
interface pixel_readout_capture_if #(
  parameter int unsigned DATA_W = 8
);
  logic              Pix_valid;
  logic              Pix_ready;
  logic [DATA_W-1:0] Pix_data;
  logic [1:0]        Pix_addr;

  modport master (
    output Pix_valid,
    output Pix_data,
    output Pix_addr,
    input  Pix_ready
  );

  modport slave (
    input  Pix_valid,
    input  Pix_data,
    input  Pix_addr,
    output Pix_ready
  );
endinterface

// File: rtl/pixel_readout_capture.sv
// Pixel-array-side capture for a 2x2 array. Follows the controller's Erase/Expose/
// NRE_1/NRE_2/ADC strobes, captures both column ADC results per row on the ADC
// falling edge, then streams the 4-word frame out over a valid/ready handshake.
//   Clk, Reset      : clock, async active-low reset
//   Erase, Expose   : controller strobes, active high
//   NRE_1, NRE_2    : row read enables, active low
//   ADC             : conversion strobe, capture on its falling edge
//   ADC_data_c1/c2  : column ADC results
//   pix             : pixel stream (master side)
//   Frame_done      : one-cycle pulse after the last word is accepted
//   Proto_err       : sticky protocol-violation flag
//   Overrun         : one-cycle pulse on an exposure start during drain
module pixel_readout_capture #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Erase,
  input  logic                Expose,
  input  logic                NRE_1,
  input  logic                NRE_2,
  input  logic                ADC,
  input  logic [DATA_W-1:0]   ADC_data_c1,
  input  logic [DATA_W-1:0]   ADC_data_c2,
  pixel_readout_capture_if.master pix,
  output logic                Frame_done,
  output logic                Proto_err,
  output logic                Overrun
);

  localparam int unsigned NUM_PIX = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXPOSE = 3'd1,
    ST_ROW1   = 3'd2,
    ST_ROW2   = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  state_t            state;
  logic              erase_q;
  logic              expose_q;
  logic              adc_q;
  logic [DATA_W-1:0] pix_buf [NUM_PIX];
  logic [1:0]        rd_ptr;
  logic              pix_valid_q;
  logic [DATA_W-1:0] pix_data_q;
  logic [1:0]        pix_addr_q;

  // Strobe edges against the one-cycle registered copies.
  logic erase_rise_c;
  logic expose_rise_c;
  logic expose_fall_c;
  logic capture_c;
  logic row1_sel_c;
  logic row2_sel_c;
  logic [1:0] rd_next_c;

  assign erase_rise_c  = Erase & ~erase_q;
  assign expose_rise_c = Expose & ~expose_q;
  assign expose_fall_c = ~Expose & expose_q;
  assign capture_c     = adc_q & ~ADC;
  assign row1_sel_c    = ~NRE_1 & NRE_2;
  assign row2_sel_c    = NRE_1 & ~NRE_2;
  assign rd_next_c     = 2'(rd_ptr + 2'd1);

  assign pix.Pix_valid = pix_valid_q;
  assign pix.Pix_data  = pix_data_q;
  assign pix.Pix_addr  = pix_addr_q;

  // Capture/drain sequencer with registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      erase_q     <= 1'b0;
      expose_q    <= 1'b0;
      adc_q       <= 1'b0;
      for (int i = 0; i < int'(NUM_PIX); i++) pix_buf[i] <= '0;
      rd_ptr      <= 2'd0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_addr_q  <= 2'd0;
      Frame_done  <= 1'b0;
      Proto_err   <= 1'b0;
      Overrun     <= 1'b0;
    end else begin
      erase_q    <= Erase;
      expose_q   <= Expose;
      adc_q      <= ADC;
      Frame_done <= 1'b0;
      Overrun    <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Erase is ignored here; a simultaneous Expose edge still starts a frame.
          if (expose_rise_c) begin
            state     <= ST_EXPOSE;
            Proto_err <= 1'b0;
          end
        end

        ST_EXPOSE: begin
          if (erase_rise_c) begin
            state <= ST_IDLE;
          end else begin
            if (capture_c) Proto_err <= 1'b1;
            if (expose_fall_c) state <= ST_ROW1;
          end
        end

        ST_ROW1: begin
          if (erase_rise_c) begin
            state <= ST_IDLE;
          end else if (expose_rise_c) begin
            Proto_err <= 1'b1;
            state     <= ST_EXPOSE;
          end else if (capture_c) begin
            if (row1_sel_c) begin
              pix_buf[0] <= ADC_data_c1;
              pix_buf[1] <= ADC_data_c2;
              state      <= ST_ROW2;
            end else begin
              Proto_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end

        ST_ROW2: begin
          if (erase_rise_c) begin
            state <= ST_IDLE;
          end else if (expose_rise_c) begin
            Proto_err <= 1'b1;
            state     <= ST_EXPOSE;
          end else if (capture_c) begin
            if (row2_sel_c) begin
              pix_buf[2] <= ADC_data_c1;
              pix_buf[3] <= ADC_data_c2;
              rd_ptr     <= 2'd0;
              state      <= ST_DRAIN;
            end else begin
              Proto_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end

        ST_DRAIN: begin
          if (expose_rise_c) Overrun <= 1'b1;
          // First DRAIN cycle presents word 0; afterwards advance only on handshake.
          if (!pix_valid_q) begin
            pix_valid_q <= 1'b1;
            pix_data_q  <= pix_buf[rd_ptr];
            pix_addr_q  <= rd_ptr;
          end else if (pix.Pix_ready) begin
            if (rd_ptr == 2'd3) begin
              pix_valid_q <= 1'b0;
              Frame_done  <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              rd_ptr     <= rd_next_c;
              pix_data_q <= pix_buf[rd_next_c];
              pix_addr_q <= rd_next_c;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_readout_capture.sv
module tb_pixel_readout_capture;

  localparam int unsigned DATA_W = 8;

  logic              Clk;
  logic              Reset;
  logic              Erase;
  logic              Expose;
  logic              NRE_1;
  logic              NRE_2;
  logic              ADC;
  logic [DATA_W-1:0] ADC_data_c1;
  logic [DATA_W-1:0] ADC_data_c2;
  logic              Frame_done;
  logic              Proto_err;
  logic              Overrun;

  int n_cmp = 0;
  int n_err = 0;

  pixel_readout_capture_if #(.DATA_W(DATA_W)) pix_if ();

  pixel_readout_capture #(.DATA_W(DATA_W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Erase       (Erase),
    .Expose      (Expose),
    .NRE_1       (NRE_1),
    .NRE_2       (NRE_2),
    .ADC         (ADC),
    .ADC_data_c1 (ADC_data_c1),
    .ADC_data_c2 (ADC_data_c2),
    .pix         (pix_if),
    .Frame_done  (Frame_done),
    .Proto_err   (Proto_err),
    .Overrun     (Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expose high for 3 cycles then low: IDLE -> EXPOSE -> ROW1.
  task automatic run_exposure();
    Expose = 1'b1;
    repeat (3) tick();
    Expose = 1'b0;
    tick();
  endtask

  // ADC pulse with the given row selects; data sampled in the falling-edge cycle.
  task automatic capture_row(input logic n1, input logic n2,
                             input logic [DATA_W-1:0] c1, input logic [DATA_W-1:0] c2);
    NRE_1 = n1;
    NRE_2 = n2;
    ADC   = 1'b1;
    tick();
    ADC         = 1'b0;
    ADC_data_c1 = c1;
    ADC_data_c2 = c2;
    tick();
    NRE_1 = 1'b1;
    NRE_2 = 1'b1;
  endtask

  // Consume a frame, holding Pix_ready low for 'stall' cycles per word.
  task automatic drain_check(input string tag,
                             input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                             input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3,
                             input int stall);
    logic [DATA_W-1:0] exp_w [4];
    int guard;
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
    guard = 0;
    if (stall == 0) pix_if.Pix_ready = 1'b1;
    while (!pix_if.Pix_valid && guard < 20) begin
      tick();
      guard++;
    end
    chk({tag, "_valid"}, 32'(pix_if.Pix_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(pix_if.Pix_data), 32'(exp_w[i]));
      chk($sformatf("%s_addr%0d", tag, i), 32'(pix_if.Pix_addr), 32'(i));
      if (stall > 0) begin
        pix_if.Pix_ready = 1'b0;
        repeat (stall) tick();
        chk($sformatf("%s_hold_v%0d", tag, i), 32'(pix_if.Pix_valid), 32'd1);
        chk($sformatf("%s_hold_d%0d", tag, i), 32'(pix_if.Pix_data), 32'(exp_w[i]));
        chk($sformatf("%s_hold_a%0d", tag, i), 32'(pix_if.Pix_addr), 32'(i));
        chk($sformatf("%s_nodone%0d", tag, i), 32'(Frame_done), 32'd0);
        pix_if.Pix_ready = 1'b1;
      end
      tick();
      if (stall > 0) pix_if.Pix_ready = 1'b0;
    end
    chk({tag, "_end_valid"}, 32'(pix_if.Pix_valid), 32'd0);
    chk({tag, "_done"}, 32'(Frame_done), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'(Frame_done), 32'd0);
    pix_if.Pix_ready = 1'b0;
  endtask

  initial begin
    Reset            = 1'b0;
    Erase            = 1'b0;
    Expose           = 1'b0;
    NRE_1            = 1'b1;
    NRE_2            = 1'b1;
    ADC              = 1'b0;
    ADC_data_c1      = '0;
    ADC_data_c2      = '0;
    pix_if.Pix_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_valid", 32'(pix_if.Pix_valid), 32'd0);
    chk("rst_data", 32'(pix_if.Pix_data), 32'd0);
    chk("rst_addr", 32'(pix_if.Pix_addr), 32'd0);
    chk("rst_done", 32'(Frame_done), 32'd0);
    chk("rst_perr", 32'(Proto_err), 32'd0);
    chk("rst_ovr", 32'(Overrun), 32'd0);
    Reset = 1'b1;
    tick();

    // Nominal frame, Pix_ready high throughout; Pix_valid two cycles after ROW2 capture
    pix_if.Pix_ready = 1'b1;
    run_exposure();
    capture_row(1'b0, 1'b1, 8'h11, 8'h22);
    capture_row(1'b1, 1'b0, 8'h33, 8'h44);
    chk("nom_lat_n1", 32'(pix_if.Pix_valid), 32'd0);
    tick();
    chk("nom_lat_n2", 32'(pix_if.Pix_valid), 32'd1);
    drain_check("nom", 8'h11, 8'h22, 8'h33, 8'h44, 0);
    chk("nom_perr", 32'(Proto_err), 32'd0);

    // Backpressure: 5 stalled cycles on every word
    run_exposure();
    capture_row(1'b0, 1'b1, 8'h11, 8'h22);
    capture_row(1'b1, 1'b0, 8'h33, 8'h44);
    drain_check("bp", 8'h11, 8'h22, 8'h33, 8'h44, 5);

    // Protocol error: both row enables low at the ROW1 capture edge
    run_exposure();
    capture_row(1'b0, 1'b0, 8'h77, 8'h88);
    chk("perr_set", 32'(Proto_err), 32'd1);
    pix_if.Pix_ready = 1'b1;
    repeat (4) tick();
    chk("perr_no_valid", 32'(pix_if.Pix_valid), 32'd0);
    chk("perr_sticky", 32'(Proto_err), 32'd1);
    pix_if.Pix_ready = 1'b0;
    Expose = 1'b1;
    tick();
    chk("perr_clear", 32'(Proto_err), 32'd0);
    tick();
    tick();
    Expose = 1'b0;
    tick();

    // Abort: Erase rising edge after the row 1 capture, then a fresh frame
    capture_row(1'b0, 1'b1, 8'h55, 8'h66);
    Erase = 1'b1;
    tick();
    Erase = 1'b0;
    repeat (3) tick();
    chk("abort_no_valid", 32'(pix_if.Pix_valid), 32'd0);
    chk("abort_perr", 32'(Proto_err), 32'd0);
    run_exposure();
    capture_row(1'b0, 1'b1, 8'hA0, 8'hA1);
    capture_row(1'b1, 1'b0, 8'hA2, 8'hA3);
    drain_check("abort", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 0);

    // Overrun: new Expose rising edge while draining with Pix_ready low
    run_exposure();
    capture_row(1'b0, 1'b1, 8'hB0, 8'hB1);
    capture_row(1'b1, 1'b0, 8'hB2, 8'hB3);
    tick();
    chk("ovr_valid", 32'(pix_if.Pix_valid), 32'd1);
    chk("ovr_idle_flag", 32'(Overrun), 32'd0);
    Expose = 1'b1;
    tick();
    chk("ovr_pulse", 32'(Overrun), 32'd1);
    chk("ovr_hold_data", 32'(pix_if.Pix_data), 32'hB0);
    Expose = 1'b0;
    tick();
    chk("ovr_pulse_end", 32'(Overrun), 32'd0);
    drain_check("ovr", 8'hB0, 8'hB1, 8'hB2, 8'hB3, 0);
    pix_if.Pix_ready = 1'b1;
    repeat (4) tick();
    chk("ovr_no_extra", 32'(pix_if.Pix_valid), 32'd0);
    chk("ovr_perr", 32'(Proto_err), 32'd0);
    pix_if.Pix_ready = 1'b0;

    // Asynchronous reset in the middle of a drain
    run_exposure();
    capture_row(1'b0, 1'b1, 8'hC0, 8'hC1);
    capture_row(1'b1, 1'b0, 8'hC2, 8'hC3);
    tick();
    chk("mrst_pre_valid", 32'(pix_if.Pix_valid), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("mrst_valid", 32'(pix_if.Pix_valid), 32'd0);
    chk("mrst_data", 32'(pix_if.Pix_data), 32'd0);
    chk("mrst_addr", 32'(pix_if.Pix_addr), 32'd0);
    chk("mrst_done", 32'(Frame_done), 32'd0);
    chk("mrst_perr", 32'(Proto_err), 32'd0);
    chk("mrst_ovr", 32'(Overrun), 32'd0);
    tick();
    tick();
    Reset = 1'b1;
    pix_if.Pix_ready = 1'b1;
    repeat (3) tick();
    chk("mrst_idle_valid", 32'(pix_if.Pix_valid), 32'd0);

    // Recovery from IDLE after reset
    run_exposure();
    capture_row(1'b0, 1'b1, 8'hD0, 8'hD1);
    capture_row(1'b1, 1'b0, 8'hD2, 8'hD3);
    drain_check("post", 8'hD0, 8'hD1, 8'hD2, 8'hD3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
